// File: rtl/usb_hid_pkg.sv
// Shared types for the HID keyboard report scheduler: key encoding, sequencer
// states and the press-report byte map.
package usb_hid_pkg;

    localparam int HID_REPORT_BYTES = 8;

    typedef struct packed {
        logic [7:0] modifier;
        logic [7:0] usage;
    } key_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        RELEASE,
        GAP
    } sched_state_t;

    // Boot-protocol layout: modifier, reserved, first usage slot, five unused slots.
    function automatic logic [7:0] press_byte(input key_t key, input logic [2:0] idx);
        case (idx)
            3'd0:    return key.modifier;
            3'd2:    return key.usage;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/usb_hid_key_fifo.sv
// Synchronous keystroke FIFO; cleared by either the system reset or a USB bus reset.
module usb_hid_key_fifo
    import usb_hid_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             usb_rstn,
    input  logic             push,
    input  key_t             push_data,
    input  logic             pop,
    output key_t             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    key_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;
    logic             flush;

    assign flush   = rst | ~usb_rstn;
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/usb_hid_key_scheduler.sv
// Round-robin keystroke arbiter feeding a FIFO, and a sequencer that emits an
// 8-byte press report followed by an 8-byte release report for every key.
module usb_hid_key_scheduler
    import usb_hid_pkg::*;
#(
    parameter  int          NREQ       = 4,
    parameter  int          FIFO_DEPTH = 8,
    parameter  logic [15:0] GAP_CYCLES = 16'd0,
    localparam int          CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 usb_rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_key,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           in_data,
    output logic                 in_valid,
    input  logic                 in_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     fifo_count
);

    localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic            flush;
    logic [RR_W-1:0] rr_ptr_reg;
    logic [RR_W-1:0] grant_idx;
    logic            grant_any;
    logic            grant_en;
    key_t            push_key;
    key_t            fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;

    sched_state_t    state_reg, state_next;
    logic [2:0]      idx_reg, idx_next;
    logic [15:0]     gap_reg, gap_next;
    key_t            key_reg, key_next;

    assign flush = rst | ~usb_rstn;

    always_comb begin : arb
        int cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = RR_W'(cand);
            end
        end
    end

    // Full comes from registered occupancy, so a same-cycle pop never frees a slot.
    assign grant_en = grant_any & ~fifo_full & ~flush;
    assign push_key = req_key[16*grant_idx +: 16];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_idx == RR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (flush) begin
            rr_ptr_reg <= '0;
        end else if (grant_en) begin
            rr_ptr_reg <= (grant_idx == RR_W'(NREQ - 1)) ? '0 : grant_idx + RR_W'(1);
        end
    end

    usb_hid_key_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .usb_rstn  (usb_rstn),
        .push      (grant_en),
        .push_data (push_key),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        gap_next   = gap_reg;
        key_next   = key_reg;
        pop        = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    key_next   = fifo_head;
                    idx_next   = 3'd0;
                    state_next = PRESS;
                end
            end
            PRESS: begin
                in_valid = 1'b1;
                in_data  = press_byte(key_reg, idx_reg);
                if (in_ready) begin
                    idx_next = idx_reg + 3'd1;
                    if (idx_reg == 3'(HID_REPORT_BYTES - 1)) begin
                        idx_next   = 3'd0;
                        state_next = RELEASE;
                    end
                end
            end
            RELEASE: begin
                in_valid = 1'b1;
                if (in_ready) begin
                    idx_next = idx_reg + 3'd1;
                    if (idx_reg == 3'(HID_REPORT_BYTES - 1)) begin
                        idx_next = 3'd0;
                        if (GAP_CYCLES != 16'd0) begin
                            gap_next   = GAP_CYCLES - 16'd1;
                            state_next = GAP;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_reg == 16'd0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            gap_reg   <= 16'd0;
            key_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            gap_reg   <= gap_next;
            key_reg   <= key_next;
        end
    end

    assign busy = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_usb_hid_key_scheduler.sv
// Directed bench for usb_hid_key_scheduler; expected report bytes are queued at
// each request handshake and checked by an independent byte monitor.
module tb_usb_hid_key_scheduler;

    localparam int          NREQ  = 4;
    localparam int          DEPTH = 8;
    localparam logic [15:0] GAP   = 16'd3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 usb_rstn = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [16*NREQ-1:0]   req_key = '0;
    logic [NREQ-1:0]      req_ready;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready = 1'b0;
    logic                 busy;
    logic [3:0]           fifo_count;

    int         total = 0;
    int         bad = 0;
    int         nacc = 0;
    logic [7:0] sb [$];
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always #5 clk = ~clk;

    usb_hid_key_scheduler #(
        .NREQ       (NREQ),
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .usb_rstn   (usb_rstn),
        .req_valid  (req_valid),
        .req_key    (req_key),
        .req_ready  (req_ready),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void expect_key(input logic [15:0] k);
        sb.push_back(k[15:8]);
        sb.push_back(8'h00);
        sb.push_back(k[7:0]);
        for (int b = 3; b < 16; b++) sb.push_back(8'h00);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [15:0] k, input int budget, output int cyc);
        req_key[16*i +: 16] = k;
        req_valid[i] = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (req_ready[i]) break;
            cyc++;
            if (cyc >= budget) begin
                total++;
                bad++;
                $display("FAIL send timeout: req %0d key %04h got no ready, required ready", i, k);
                req_valid[i] = 1'b0;
                return;
            end
        end
        expect_key(k);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        $display("req %0d key %04h accepted after %0d cycles", i, k, cyc);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain", (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Byte monitor: scoreboard compare on each accept, hold check on each stall.
    always @(negedge clk) begin : mon
        logic [7:0] exp_b;
        if (rst || !usb_rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if (!in_valid || in_data !== stall_data) begin
                    bad++;
                    $display("FAIL hold: got valid=%0b data=%02h required valid=1 data=%02h",
                             in_valid, in_data, stall_data);
                end
            end
            if (in_valid && in_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL byte: got unexpected %02h required no byte", in_data);
                end else begin
                    exp_b = sb.pop_front();
                    if (in_data !== exp_b) begin
                        bad++;
                        $display("FAIL byte: got %02h required %02h", in_data, exp_b);
                    end
                end
                nacc++;
            end
            stall_prev = in_valid && !in_ready;
            stall_data = in_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, hi, z, ph, base;
        logic blocked;
        logic [15:0] order [5];
        logic [3:0]  oh [5];

        // Reset with requests pending: nothing may be granted.
        req_valid = 4'hF;
        req_key   = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        in_ready  = 1'b1;
        repeat (3) tick();
        chk("reset req_ready", req_ready, 4'h0);
        chk("reset in_valid", in_valid, 1'b0);
        chk("reset in_data", in_data, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset fifo_count", fifo_count, 4'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();
        chk("post-reset in_valid", in_valid, 1'b0);

        // Single key: latency 2, 16 valid cycles.
        send(3, 16'h0204, 20, cyc);
        chk("latency t+1 in_valid", in_valid, 1'b0);
        tick();
        chk("latency t+2 in_valid", in_valid, 1'b1);
        chk("latency t+2 in_data", in_data, 8'h02);
        hi = 1;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (in_valid) hi++;
        end
        chk("single valid cycles", hi, 16);
        chk("single idle busy", busy, 1'b0);

        // Simultaneous requests, plus requester 0 re-requesting while 1..3 wait.
        order = '{16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
        oh    = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        req_key   = {16'h0007, 16'h0006, 16'h0005, 16'h0004};
        req_valid = 4'hF;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk($sformatf("rr grant %0d", s), req_ready, oh[s]);
            expect_key(order[s]);
            $display("rr step %0d key %04h", s, order[s]);
            @(posedge clk);
            #1;
            if (s == 0) req_key[15:0] = 16'h0008;
            else        req_valid[s % 4] = 1'b0;
        end
        wait_drain(300);

        // Backpressure: one key in the sequencer plus eight in the FIFO.
        in_ready = 1'b0;
        for (int k = 0; k < 9; k++) send(2, 16'hA100 | 16'(k), 20, cyc);
        tick();
        chk("bp fifo_count", fifo_count, 4'd8);
        chk("bp busy", busy, 1'b1);
        req_key[47:32] = 16'hA109;
        req_valid[2]   = 1'b1;
        blocked = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (req_ready != 4'h0) blocked = 1'b1;
        end
        chk("bp req_ready blocked", blocked, 1'b0);
        @(posedge clk);
        #1;
        in_ready = 1'b1;
        send(2, 16'hA109, 60, cyc);
        chk("bp 10th wait cycles", cyc, 20);
        wait_drain(600);

        // in_ready toggling, including an all-zero key.
        in_ready = 1'b0;
        send(1, 16'hE12B, 20, cyc);
        send(3, 16'h0000, 20, cyc);
        base = nacc;
        for (int n = 0; n < 300 && (sb.size() != 0 || busy); n++) begin
            in_ready = ~in_ready;
            tick();
        end
        in_ready = 1'b1;
        chk("toggle bytes", nacc - base, 32);
        chk("toggle drained", sb.size(), 0);

        // USB bus reset at press byte 5 with keys queued.
        in_ready = 1'b0;
        send(0, 16'h1111, 20, cyc);
        send(1, 16'h2222, 20, cyc);
        send(2, 16'h3333, 20, cyc);
        base = nacc;
        in_ready = 1'b1;
        for (int n = 0; n < 60 && nacc != base + 5; n++) tick();
        chk("flush reached byte 5", nacc - base, 5);
        usb_rstn = 1'b0;
        req_key[63:48] = 16'h7777;
        req_valid[3]   = 1'b1;
        #1;
        chk("flush req_ready", req_ready, 4'h0);
        tick();
        usb_rstn = 1'b1;
        req_valid[3] = 1'b0;
        chk("flush in_valid", in_valid, 1'b0);
        chk("flush fifo_count", fifo_count, 4'd0);
        chk("flush busy", busy, 1'b0);
        sb.delete();
        hi = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (in_valid) hi++;
        end
        chk("flush quiet", hi, 0);
        base = nacc;
        send(0, 16'h0029, 20, cyc);
        wait_drain(100);
        chk("after flush bytes", nacc - base, 16);

        // Gap between two queued keys: 3 GAP cycles plus 1 IDLE cycle.
        in_ready = 1'b0;
        send(0, 16'h0102, 20, cyc);
        send(1, 16'h0304, 20, cyc);
        tick();
        in_ready = 1'b1;
        hi = 0;
        z  = 0;
        ph = 0;
        for (int n = 0; n < 80 && ph < 2; n++) begin
            if (ph == 0) begin
                if (in_valid) hi++;
                else if (hi > 0) begin ph = 1; z = 1; end
            end else begin
                if (in_valid) ph = 2;
                else z++;
            end
            if (ph < 2) tick();
        end
        chk("gap first run", hi, 16);
        chk("gap idle cycles", z, 4);
        wait_drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
